dispatch_unit: RTL and testbench

//  Initiator side of the execute interface. Accepts one decoded instruction

---
 rtl/dispatch_pkg.sv | 24 ++
 rtl/dispatch_if.sv | 45 ++++
 rtl/dispatch_watchdog.sv | 33 +++
 rtl/dispatch_unit.sv | 132 +++++++++++++
 tb/tb_dispatch_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_pkg.sv
// Shared types and constants for the single-issue dispatch unit.
package dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT     = 2'd2,
    COMPLETE = 2'd3
  } disp_state_t;

  localparam logic [2:0] RS_INTEGER    = 3'b000;
  localparam logic [2:0] RS_LOAD_STORE = 3'b001;
  localparam logic [2:0] RS_BRANCH     = 3'b010;
  localparam logic [2:0] RS_NONE       = 3'b111;

  localparam int INT_W = 76;
  localparam int LS_W  = 104;
  localparam int BR_W  = 106;

  function automatic logic rs_known(input logic [2:0] code);
    return (code == RS_INTEGER) || (code == RS_LOAD_STORE) || (code == RS_BRANCH);
  endfunction

endpackage

// File: rtl/dispatch_if.sv
// Decode/Execute/retire bundle seen by the dispatch unit (master) and its environment.
interface dispatch_if #(parameter int XLEN = 32) ();
  import dispatch_pkg::*;

  logic             kill;
  logic             stall;
  logic             dec_valid;
  logic             dec_ready;
  logic [XLEN-1:0]  dec_pc;
  logic [2:0]       dec_dest;
  logic [INT_W-1:0] dec_integer;
  logic [LS_W-1:0]  dec_loadstore;
  logic [BR_W-1:0]  dec_branch;
  logic [XLEN-1:0]  dispatched_pc;
  logic [2:0]       rs_destination;
  logic [INT_W-1:0] rs_integer;
  logic [LS_W-1:0]  rs_loadstore;
  logic [BR_W-1:0]  rs_branch;
  logic             finish_ex;
  logic [XLEN-1:0]  nextpc;
  logic [4:0]       complete_rd;
  logic [XLEN-1:0]  complete_data;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             timeout_err;

  modport master (
    input  kill, stall, dec_valid, dec_pc, dec_dest, dec_integer, dec_loadstore,
           dec_branch, finish_ex, nextpc, complete_rd, complete_data,
    output dec_ready, dispatched_pc, rs_destination, rs_integer, rs_loadstore,
           rs_branch, rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_pc,
           timeout_err
  );

  modport slave (
    output kill, stall, dec_valid, dec_pc, dec_dest, dec_integer, dec_loadstore,
           dec_branch, finish_ex, nextpc, complete_rd, complete_data,
    input  dec_ready, dispatched_pc, rs_destination, rs_integer, rs_loadstore,
           rs_branch, rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_pc,
           timeout_err
  );
endinterface

// File: rtl/dispatch_watchdog.sv
// WAIT-cycle counter; expires on the last allowed WAIT cycle.
module dispatch_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] timer_q, timer_d;

  assign expire_o = count_i && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (count_i && !expire_o) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
endmodule

// File: rtl/dispatch_unit.sv
// Single-in-flight dispatcher: issues one decoded op to Execute, retires it, redirects fetch.
//   state    | meaning
//   IDLE     | ready for a new op from decode
//   ISSUE    | op presented to Execute for its latch cycle
//   WAIT     | waiting for a finish_ex rising edge or watchdog expiry
//   COMPLETE | one-cycle retire: redirect pulse and optional rf write
module dispatch_unit
  import dispatch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int XLEN           = 32
) (
  input logic         clk,
  input logic         reset,
  dispatch_if.master  bus
);
  disp_state_t state_q, state_d;

  logic [XLEN-1:0]  pc_q;
  logic [2:0]       dest_q;
  logic [INT_W-1:0] int_q;
  logic [LS_W-1:0]  ls_q;
  logic [BR_W-1:0]  br_q;
  logic [XLEN-1:0]  redir_pc_q;
  logic [4:0]       waddr_q;
  logic [XLEN-1:0]  wdata_q;
  logic             we_q;
  logic             fin_q;
  logic             timeout_q;

  logic dec_ready_w;
  logic accept;
  logic done;
  logic expire;

  // Reset is folded in so decode never sees a ready while the block is held in reset.
  assign dec_ready_w = (state_q == IDLE) && !bus.stall && !bus.kill && reset;
  assign accept      = bus.dec_valid && dec_ready_w;
  assign done        = bus.finish_ex && !fin_q;

  dispatch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst_n    (reset),
    .clear_i  (state_q == ISSUE),
    .count_i  (state_q == WAIT),
    .expire_o (expire)
  );

  always_comb begin
    state_d                = state_q;
    bus.rs_destination     = RS_NONE;
    bus.redirect_valid     = 1'b0;
    bus.rf_we              = 1'b0;
    if (bus.kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) state_d = rs_known(bus.dec_dest) ? ISSUE : COMPLETE;
        end
        ISSUE: begin
          state_d            = WAIT;
          bus.rs_destination = dest_q;
        end
        WAIT: begin
          bus.rs_destination = dest_q;
          if (done || expire) state_d = COMPLETE;
        end
        COMPLETE: begin
          state_d            = IDLE;
          bus.redirect_valid = 1'b1;
          bus.rf_we          = we_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      dest_q     <= RS_NONE;
      int_q      <= '0;
      ls_q       <= '0;
      br_q       <= '0;
      redir_pc_q <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      fin_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fin_q   <= bus.finish_ex;
      if (accept) begin
        pc_q   <= bus.dec_pc;
        dest_q <= bus.dec_dest;
        int_q  <= bus.dec_integer;
        ls_q   <= bus.dec_loadstore;
        br_q   <= bus.dec_branch;
        // Unknown RS codes bypass Execute and just step fetch past the op.
        if (!rs_known(bus.dec_dest)) begin
          redir_pc_q <= bus.dec_pc + XLEN'(4);
          we_q       <= 1'b0;
        end
      end
      if (state_q == WAIT && !bus.kill) begin
        if (done) begin
          redir_pc_q <= bus.nextpc;
          waddr_q    <= bus.complete_rd;
          wdata_q    <= bus.complete_data;
          we_q       <= (dest_q != RS_BRANCH) && (bus.complete_rd != 5'd0);
        end else if (expire) begin
          redir_pc_q <= pc_q + XLEN'(4);
          we_q       <= 1'b0;
          timeout_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.dec_ready     = dec_ready_w;
  assign bus.dispatched_pc = pc_q;
  assign bus.rs_integer    = int_q;
  assign bus.rs_loadstore  = ls_q;
  assign bus.rs_branch     = br_q;
  assign bus.rf_waddr      = waddr_q;
  assign bus.rf_wdata      = wdata_q;
  assign bus.redirect_pc   = redir_pc_q;
  assign bus.timeout_err   = timeout_q;
endmodule

// File: tb/tb_dispatch_unit.sv
// Directed, table-driven bench for dispatch_unit with hand sequences for multi-cycle corners.
module tb_dispatch_unit;
  import dispatch_pkg::*;

  localparam int TO  = 8;
  localparam int WIN = 14;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dispatch_if #(.XLEN(32)) bus ();

  dispatch_unit #(.TIMEOUT_CYCLES(TO), .XLEN(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    logic [2:0]  dest;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] npc;
    int          fin_low;
    int          fin_delay;
    logic        exp_we;
    logic [31:0] exp_rpc;
    int          exp_lat;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Issues one op, drives finish_ex on the vector's schedule and checks the retire outcome.
  task automatic do_vec(input string tag, input vec_t v, input bit hold);
    int          n_redir, n_we, lat;
    logic [31:0] r_pc, w_data;
    logic [4:0]  w_addr;
    logic [2:0]  exp_rsd;
    n_redir = 0; n_we = 0; lat = -1;
    r_pc = '0; w_data = '0; w_addr = '0;
    exp_rsd = (v.dest == RS_INTEGER || v.dest == RS_LOAD_STORE || v.dest == RS_BRANCH)
              ? v.dest : RS_NONE;
    @(negedge clk);
    bus.dec_pc        = v.pc;
    bus.dec_dest      = v.dest;
    bus.dec_integer   = {v.pc, v.pc, 12'hA5A};
    bus.dec_loadstore = {v.pc, v.pc, v.pc, 8'h3C};
    bus.dec_branch    = {v.pc, v.pc, v.pc, 10'h2B1};
    bus.nextpc        = v.npc;
    bus.complete_rd   = v.rd;
    bus.complete_data = v.data;
    bus.dec_valid     = 1'b1;
    #1 chk({tag, "_dec_ready"}, bus.dec_ready, 1'b1);
    @(negedge clk);
    bus.dec_valid = 1'b0;
    #1;
    chk({tag, "_dispatched_pc"}, bus.dispatched_pc, v.pc);
    chk({tag, "_rs_destination"}, bus.rs_destination, exp_rsd);
    chk({tag, "_rs_integer"}, bus.rs_integer, {v.pc, v.pc, 12'hA5A});
    chk({tag, "_rs_loadstore"}, bus.rs_loadstore, {v.pc, v.pc, v.pc, 8'h3C});
    chk({tag, "_rs_branch"}, bus.rs_branch, {v.pc, v.pc, v.pc, 10'h2B1});
    for (int c = 0; c < WIN; c++) begin
      if (!hold && n_redir > 0) bus.finish_ex = 1'b0;
      if (v.fin_low != 0 && c == v.fin_low) bus.finish_ex = 1'b0;
      if (v.fin_delay != 0 && c == v.fin_delay) bus.finish_ex = 1'b1;
      #1;
      if (bus.redirect_valid) begin
        n_redir++;
        r_pc = bus.redirect_pc;
        if (lat < 0) lat = c;
      end
      if (bus.rf_we) begin
        n_we++;
        w_addr = bus.rf_waddr;
        w_data = bus.rf_wdata;
      end
      @(negedge clk);
    end
    #1;
    chk({tag, "_back_to_idle"}, bus.dec_ready, 1'b1);
    chk({tag, "_redirect_count"}, 128'(n_redir), 128'd1);
    chk({tag, "_redirect_pc"}, r_pc, v.exp_rpc);
    chk({tag, "_rf_we_count"}, 128'(n_we), v.exp_we ? 128'd1 : 128'd0);
    chk({tag, "_latency"}, 128'(lat), 128'(v.exp_lat));
    if (v.exp_we) begin
      chk({tag, "_rf_waddr"}, w_addr, v.rd);
      chk({tag, "_rf_wdata"}, w_data, v.data);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n_redir, n_we;
    bus.kill = 0; bus.stall = 0; bus.dec_valid = 0; bus.dec_pc = '0; bus.dec_dest = RS_NONE;
    bus.dec_integer = '0; bus.dec_loadstore = '0; bus.dec_branch = '0;
    bus.finish_ex = 0; bus.nextpc = '0; bus.complete_rd = '0; bus.complete_data = '0;

    //            dest           pc            rd     data           npc           low dly we    rpc           lat
    tbl[0] = '{RS_INTEGER,    32'h0000_0100, 5'd5,  32'h0000_002A, 32'h0000_0104, 0, 2, 1'b1, 32'h0000_0104, 3};
    tbl[1] = '{RS_BRANCH,     32'h0000_0200, 5'd7,  32'h0000_0055, 32'h0000_0080, 0, 2, 1'b0, 32'h0000_0080, 3};
    tbl[2] = '{RS_LOAD_STORE, 32'h0000_0300, 5'd0,  32'h0000_0099, 32'h0000_0304, 0, 1, 1'b0, 32'h0000_0304, 2};
    tbl[3] = '{RS_LOAD_STORE, 32'h0000_0400, 5'd31, 32'hDEAD_BEEF, 32'h0000_1000, 0, 5, 1'b1, 32'h0000_1000, 6};
    tbl[4] = '{3'b011,        32'hFFFF_FFFC, 5'd3,  32'h0000_0001, 32'h0000_0500, 0, 0, 1'b0, 32'h0000_0000, 0};
    tbl[5] = '{RS_INTEGER,    32'h0000_0600, 5'd1,  32'h1234_5678, 32'h0000_0604, 0, 7, 1'b1, 32'h0000_0604, 8};

    // Reset values
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_dec_ready", bus.dec_ready, 1'b0);
    chk("rst_rs_destination", bus.rs_destination, RS_NONE);
    chk("rst_pcs", {bus.dispatched_pc, bus.redirect_pc}, 64'd0);
    chk("rst_payloads", {bus.rs_integer, bus.rs_branch[51:0]}, 128'd0);
    chk("rst_rf", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, 38'd0);
    chk("rst_flags", {bus.redirect_valid, bus.timeout_err}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) do_vec($sformatf("vec%0d", i), tbl[i], 1'b0);
    chk("no_timeout_yet", bus.timeout_err, 1'b0);

    // finish_ex held high across three back-to-back ops; only fresh rising edges retire
    do_vec("sticky_a", '{RS_INTEGER,    32'h800, 5'd2, 32'h11, 32'h804, 0, 2, 1'b1, 32'h804, 3}, 1'b1);
    do_vec("sticky_b", '{RS_LOAD_STORE, 32'h900, 5'd3, 32'h22, 32'h904, 3, 4, 1'b1, 32'h904, 5}, 1'b1);
    do_vec("sticky_c", '{RS_INTEGER,    32'hA00, 5'd6, 32'h33, 32'hA04, 2, 3, 1'b1, 32'hA04, 4}, 1'b1);
    bus.finish_ex = 1'b0;

    // kill in WAIT together with a finish_ex rising edge
    @(negedge clk);
    bus.dec_pc = 32'hB00; bus.dec_dest = RS_INTEGER; bus.nextpc = 32'hB04;
    bus.complete_rd = 5'd9; bus.complete_data = 32'h44; bus.dec_valid = 1'b1;
    @(negedge clk); bus.dec_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.finish_ex = 1'b1; bus.kill = 1'b1;
    #1;
    chk("kill_rs_none", bus.rs_destination, RS_NONE);
    chk("kill_ready_low", bus.dec_ready, 1'b0);
    @(negedge clk); bus.kill = 1'b0;
    #1;
    chk("kill_idle_ready", bus.dec_ready, 1'b1);
    n_redir = 0; n_we = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.redirect_valid) n_redir++;
      if (bus.rf_we) n_we++;
      @(negedge clk); #1;
    end
    chk("kill_no_redirect", 128'(n_redir), 128'd0);
    chk("kill_no_rf_we", 128'(n_we), 128'd0);
    bus.finish_ex = 1'b0;

    // stall blocks acceptance only
    @(negedge clk);
    bus.stall = 1'b1; bus.dec_valid = 1'b1;
    bus.dec_pc = 32'hC00; bus.dec_dest = RS_INTEGER; bus.nextpc = 32'hC04;
    bus.complete_rd = 5'd10; bus.complete_data = 32'h55;
    #1 chk("stall_ready_low", bus.dec_ready, 1'b0);
    @(negedge clk); #1;
    chk("stall_no_issue", bus.rs_destination, RS_NONE);
    @(negedge clk); bus.stall = 1'b0;
    #1 chk("stall_release_ready", bus.dec_ready, 1'b1);
    @(negedge clk); bus.dec_valid = 1'b0; bus.stall = 1'b1;
    #1 chk("stall_issued", bus.rs_destination, RS_INTEGER);
    @(negedge clk); bus.finish_ex = 1'b1;
    n_redir = 0; n_we = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.redirect_valid) begin
        n_redir++;
        chk("stall_redirect_pc", bus.redirect_pc, 32'hC04);
      end
      if (bus.rf_we) begin
        n_we++;
        chk("stall_rf_wdata", bus.rf_wdata, 32'h55);
      end
      @(negedge clk);
    end
    chk("stall_completes", 128'(n_redir), 128'd1);
    chk("stall_rf_once", 128'(n_we), 128'd1);
    bus.finish_ex = 1'b0; bus.stall = 1'b0;

    // watchdog: no finish_ex at all
    do_vec("timeout", '{RS_INTEGER, 32'h700, 5'd4, 32'h77, 32'h999, 0, 0, 1'b0, 32'h704, 9}, 1'b0);
    chk("timeout_err_set", bus.timeout_err, 1'b1);
    @(negedge clk); #1;
    chk("timeout_err_sticky", bus.timeout_err, 1'b1);

    // asynchronous reset mid-op
    @(negedge clk);
    bus.dec_pc = 32'hD00; bus.dec_dest = RS_LOAD_STORE; bus.dec_valid = 1'b1;
    @(negedge clk); bus.dec_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rs_none", bus.rs_destination, RS_NONE);
    chk("midrst_pc", bus.dispatched_pc, 32'd0);
    chk("midrst_timeout_clr", bus.timeout_err, 1'b0);
    chk("midrst_ready", bus.dec_ready, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready", bus.dec_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
